// File: rtl/video_timing_source.sv
// rtl/video_timing_source.sv - raster timing generator and ready-strobed pixel source.
// Optional colour-bar test pattern and test_mode_i port when TEST_PATTERN_EN is defined.
module video_timing_source #(
   parameter int H_ACTIVE = 1280,
   parameter int H_FP     = 110,
   parameter int H_SYNC   = 40,
   parameter int H_BP     = 220,
   parameter int V_ACTIVE = 720,
   parameter int V_FP     = 5,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 20
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        enable_i,
`ifdef TEST_PATTERN_EN
   input  logic        test_mode_i,
`endif
   output logic        pixel_req_o,
   output logic [10:0] req_x_o,
   output logic [9:0]  req_y_o,
   input  logic [31:0] pixel_in_i,
   input  logic        pixel_valid_i,
   output logic        video_ready_o,
   output logic [31:0] pixel_out_o,
   output logic        hsync_o,
   output logic        vsync_o,
   output logic        frame_start_o,
   output logic        underflow_o,
   input  logic        clear_err_i
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_ACT_C   = 11'(H_ACTIVE);
   localparam logic [10:0] H_SYNC_S  = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] H_SYNC_E  = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
   localparam logic [9:0]  V_ACT_C   = 10'(V_ACTIVE);
   localparam logic [9:0]  V_SYNC_S  = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  V_SYNC_E  = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);

   generate
      if (H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_size_check
         $error("video_timing_source: raster totals do not fit the 11/10-bit counters");
      end
   endgenerate

   typedef enum logic {ST_IDLE, ST_RUN} state_e;

   state_e      state_q, state_d;
   logic        run;
   logic [10:0] h_cnt_q, h_cnt_d;
   logic [9:0]  v_cnt_q, v_cnt_d;
   logic        h_last, v_last, frame_end;

   logic        active, hs0, vs0, first0;
   logic        s1_req_q, s1_hs_q, s1_vs_q, s1_first_q;
   logic        video_ready_q, hsync_q, vsync_q, frame_start_q, underflow_q, underflow_d;
   logic [31:0] pixel_out_q, pixel_out_d;
   logic        miss;

   assign h_last    = (h_cnt_q == H_LAST);
   assign v_last    = (v_cnt_q == V_LAST);
   assign frame_end = run && h_last && v_last;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Leaving RUN is only allowed at the frame boundary so a frame is never truncated.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (enable_i) state_d = ST_RUN;
         ST_RUN:  if (frame_end && !enable_i) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      run = (state_q == ST_RUN);
   end

   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (!run) begin
         h_cnt_d = '0;
         v_cnt_d = '0;
      end else if (h_last) begin
         h_cnt_d = '0;
         v_cnt_d = v_last ? '0 : v_cnt_q + 10'd1;
      end else begin
         h_cnt_d = h_cnt_q + 11'd1;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   assign active      = run && (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
   assign pixel_req_o = active;
   assign req_x_o     = active ? h_cnt_q : 11'd0;
   assign req_y_o     = active ? v_cnt_q : 10'd0;

   assign hs0    = run && (h_cnt_q >= H_SYNC_S) && (h_cnt_q < H_SYNC_E);
   assign vs0    = run && (v_cnt_q >= V_SYNC_S) && (v_cnt_q < V_SYNC_E);
   assign first0 = active && (h_cnt_q == 11'd0) && (v_cnt_q == 10'd0);

`ifdef TEST_PATTERN_EN
   logic       mode_q;
   logic [2:0] s1_bar_q;

   function automatic logic [31:0] bar_colour(input logic [2:0] bar);
      case (bar)
         3'd0:    bar_colour = 32'h00FF_FFFF;
         3'd1:    bar_colour = 32'h00FF_FF00;
         3'd2:    bar_colour = 32'h0000_FFFF;
         3'd3:    bar_colour = 32'h0000_FF00;
         3'd4:    bar_colour = 32'h00FF_00FF;
         3'd5:    bar_colour = 32'h00FF_0000;
         3'd6:    bar_colour = 32'h0000_00FF;
         default: bar_colour = 32'h0000_0000;
      endcase
   endfunction

   // test_mode is only picked up between frames so a frame is never half pattern.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         mode_q   <= 1'b0;
         s1_bar_q <= '0;
      end else begin
         if (!run || frame_end) mode_q <= test_mode_i;
         s1_bar_q <= req_x_o[10:8];
      end
   end
`endif

   always_comb begin
      pixel_out_d = '0;
      miss        = 1'b0;
      if (s1_req_q) begin
`ifdef TEST_PATTERN_EN
         if (mode_q) begin
            pixel_out_d = bar_colour(s1_bar_q);
         end else begin
            pixel_out_d = pixel_valid_i ? pixel_in_i : 32'h0;
            miss        = !pixel_valid_i;
         end
`else
         pixel_out_d = pixel_valid_i ? pixel_in_i : 32'h0;
         miss        = !pixel_valid_i;
`endif
      end
   end

   // A new miss outranks a simultaneous clear so no error is ever lost.
   always_comb begin
      underflow_d = underflow_q;
      if (miss) underflow_d = 1'b1;
      else if (clear_err_i) underflow_d = 1'b0;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         s1_req_q      <= 1'b0;
         s1_hs_q       <= 1'b0;
         s1_vs_q       <= 1'b0;
         s1_first_q    <= 1'b0;
         video_ready_q <= 1'b0;
         pixel_out_q   <= '0;
         hsync_q       <= 1'b0;
         vsync_q       <= 1'b0;
         frame_start_q <= 1'b0;
         underflow_q   <= 1'b0;
      end else begin
         s1_req_q      <= active;
         s1_hs_q       <= hs0;
         s1_vs_q       <= vs0;
         s1_first_q    <= first0;
         video_ready_q <= s1_req_q;
         pixel_out_q   <= pixel_out_d;
         hsync_q       <= s1_hs_q;
         vsync_q       <= s1_vs_q;
         frame_start_q <= s1_first_q;
         underflow_q   <= underflow_d;
      end
   end

   assign video_ready_o = video_ready_q;
   assign pixel_out_o   = pixel_out_q;
   assign hsync_o       = hsync_q;
   assign vsync_o       = vsync_q;
   assign frame_start_o = frame_start_q;
   assign underflow_o   = underflow_q;

endmodule

// File: tb/tb_video_timing_source.sv
// tb/tb_video_timing_source.sv - self-checking bench for video_timing_source (small raster).
module tb_video_timing_source;
   localparam int HA = 8, HF = 2, HS = 2, HB = 2;
   localparam int VA = 4, VF = 1, VS = 1, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FRAME = HT * VT;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic        pixel_req;
   logic [10:0] req_x;
   logic [9:0]  req_y;
   logic [31:0] pixel_in = '0;
   logic        pixel_valid = 1'b0;
   logic        video_ready;
   logic [31:0] pixel_out;
   logic        hsync, vsync, frame_start, underflow;
   logic        clear_err = 1'b0;
`ifdef TEST_PATTERN_EN
   logic        test_mode = 1'b0;
`endif

   always #5 clk = ~clk;

   video_timing_source #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
   ) dut (
      .clk_i(clk),
      .reset_i(reset),
      .enable_i(enable),
`ifdef TEST_PATTERN_EN
      .test_mode_i(test_mode),
`endif
      .pixel_req_o(pixel_req),
      .req_x_o(req_x),
      .req_y_o(req_y),
      .pixel_in_i(pixel_in),
      .pixel_valid_i(pixel_valid),
      .video_ready_o(video_ready),
      .pixel_out_o(pixel_out),
      .hsync_o(hsync),
      .vsync_o(vsync),
      .frame_start_o(frame_start),
      .underflow_o(underflow),
      .clear_err_i(clear_err)
   );

   typedef struct {
      bit req;
      int x;
      int y;
      bit hs;
      bit vs;
      bit first;
   } info_t;

   typedef struct {
      int steps;
      bit en;
      int drop_at;
      int clr_at;
      bit rnd;
      int exp_vr;
      int exp_fs;
      int exp_uf;
   } seg_t;

   int    checks = 0;
   int    failures = 0;
   bit    m_run;
   int    m_t;
   bit    m_uf;
   info_t d1;
   int    cnt_vr, cnt_fs, step_no, fs_step;
   seg_t  segs [8];

   // Raster position t within a frame maps to (t % HT, t / HT); everything follows from that.
   function automatic info_t info_at(input bit run, input int t);
      info_t r;
      int h, v;
      h = t % HT;
      v = t / HT;
      r.req   = run && (h < HA) && (v < VA);
      r.x     = r.req ? h : 0;
      r.y     = r.req ? v : 0;
      r.hs    = run && (h >= HA + HF) && (h < HA + HF + HS);
      r.vs    = run && (v >= VA + VF) && (v < VA + VF + VS);
      r.first = run && (t == 0);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run = 1'b0;
      m_t   = 0;
      m_uf  = 1'b0;
      d1    = info_at(1'b0, 0);
   endtask

   task automatic step(input bit en, input bit pv, input bit clr);
      logic [31:0] pin;
      logic [31:0] e_po;
      bit          e_vr, e_hs, e_vs, e_fs;
      info_t       cur;
      pin         = $urandom;
      enable      = en;
      pixel_valid = pv;
      clear_err   = clr;
      pixel_in    = pin;
      @(posedge clk);
      cur  = info_at(m_run, m_t);
      e_vr = d1.req;
      e_hs = d1.hs;
      e_vs = d1.vs;
      e_fs = d1.first;
      e_po = (d1.req && pv) ? pin : 32'h0;
      if (d1.req && !pv) m_uf = 1'b1;
      else if (clr) m_uf = 1'b0;
      d1 = cur;
      if (!m_run) begin
         if (en) begin
            m_run = 1'b1;
            m_t   = 0;
         end
      end else if (m_t == FRAME - 1) begin
         m_t   = 0;
         m_run = en;
      end else begin
         m_t++;
      end
      #1;
      cur = info_at(m_run, m_t);
      chk("pixel_req", pixel_req, cur.req);
      chk("req_x", req_x, cur.x);
      chk("req_y", req_y, cur.y);
      chk("video_ready", video_ready, e_vr);
      chk("pixel_out", pixel_out, e_po);
      chk("hsync", hsync, e_hs);
      chk("vsync", vsync, e_vs);
      chk("frame_start", frame_start, e_fs);
      chk("underflow", underflow, m_uf);
      step_no++;
      if (video_ready === 1'b1) cnt_vr++;
      if (frame_start === 1'b1) begin
         cnt_fs++;
         if (fs_step < 0) fs_step = step_no;
      end
   endtask

   task automatic do_reset();
      #3;
      reset       = 1'b1;
      enable      = 1'b0;
      pixel_valid = 1'b0;
      clear_err   = 1'b0;
      pixel_in    = '0;
      #1;
      chk("rst_pixel_req", pixel_req, 0);
      chk("rst_req_x", req_x, 0);
      chk("rst_req_y", req_y, 0);
      chk("rst_video_ready", video_ready, 0);
      chk("rst_pixel_out", pixel_out, 0);
      chk("rst_hsync", hsync, 0);
      chk("rst_vsync", vsync, 0);
      chk("rst_frame_start", frame_start, 0);
      chk("rst_underflow", underflow, 0);
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      bit pv, clr;
      //           steps en drop clr rnd vr fs uf(2 = any)
      segs[0] = '{100, 1'b1, -1, -1, 1'b0, 32, 1, 0};  // first frame from IDLE
      segs[1] = '{ 98, 1'b1, -1, -1, 1'b0, 32, 1, 0};  // back-to-back frame
      segs[2] = '{ 98, 1'b0, -1, -1, 1'b0, 32, 1, 0};  // enable dropped: frame finishes
      segs[3] = '{ 50, 1'b0, -1, -1, 1'b0,  0, 0, 0};  // idle
      segs[4] = '{100, 1'b1,  3, -1, 1'b0, 32, 1, 1};  // miss on pixel (0,0)
      segs[5] = '{ 98, 1'b1, -1,  5, 1'b0, 32, 1, 0};  // clear_err
      segs[6] = '{ 98, 1'b1,  5,  5, 1'b0, 32, 1, 1};  // miss coincident with clear
      segs[7] = '{196, 1'b1, -1, -1, 1'b1, 64, 2, 2};  // random valid / clear

      model_reset();
      fs_step = -1;
      step_no = 0;
      do_reset();

      for (int s = 0; s < 8; s++) begin
         cnt_vr = 0;
         cnt_fs = 0;
         for (int j = 1; j <= segs[s].steps; j++) begin
            pv  = 1'b1;
            clr = 1'b0;
            if (segs[s].rnd) begin
               pv  = ($urandom_range(5) != 0);
               clr = ($urandom_range(15) == 0);
            end
            if (j == segs[s].drop_at) pv = 1'b0;
            if (j == segs[s].clr_at) clr = 1'b1;
            step(segs[s].en, pv, clr);
         end
         chk($sformatf("seg%0d_ready_count", s), cnt_vr, segs[s].exp_vr);
         chk($sformatf("seg%0d_frame_start_count", s), cnt_fs, segs[s].exp_fs);
         if (segs[s].exp_uf != 2) chk($sformatf("seg%0d_underflow_end", s), underflow, segs[s].exp_uf);
      end

      // Run into the middle of line 1, then hit reset while pixels are in flight.
      for (int j = 0; j < 20; j++) step(1'b1, 1'b1, 1'b0);
      chk("pre_reset_running", pixel_req, 1);
      do_reset();

      cnt_vr  = 0;
      cnt_fs  = 0;
      step_no = 0;
      fs_step = -1;
      for (int j = 0; j < 100; j++) step(1'b1, 1'b1, 1'b0);
      chk("restart_ready_count", cnt_vr, 32);
      chk("restart_frame_start_count", cnt_fs, 1);
      chk("restart_frame_start_step", fs_step, 3);
      chk("restart_underflow", underflow, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
